// File: rtl/mavg_ctrl.sv
// Sequencing controller for a moving-average engine: paces samples, resets the engine on
// reconfiguration, hides warm-up results and buffers valid results in a one-entry output stage.
module mavg_ctrl #(
   parameter int DW = 16,
   parameter int PW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_en,
   input  logic [2:0]           cfg_mode,
   input  logic                 cfg_orm,
   input  logic [PW-1:0]        cfg_period,
   input  logic                 clr_status,
   input  logic signed [DW-1:0] src_data,
   input  logic                 src_valid,
   output logic                 src_ready,
   output logic                 eng_rst_n,
   output logic                 eng_enable,
   output logic                 eng_data_refresh,
   output logic signed [DW-1:0] eng_din,
   output logic [2:0]           eng_mode,
   output logic                 eng_orm,
   input  logic signed [DW-1:0] eng_dout,
   input  logic                 eng_pulse,
   output logic signed [DW-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 underrun,
   output logic                 overrun,
   output logic [1:0]           state
);

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_ENG_RST = 2'b01;
   localparam logic [1:0] S_WARMUP  = 2'b10;
   localparam logic [1:0] S_RUN     = 2'b11;

   logic [PW-1:0] period_sh;
   logic [PW-1:0] tick_cnt;
   logic          rst_cnt;
   logic [4:0]    ref_cnt;
   logic          fwd_r;
   logic          fwd_p;

   logic          running;
   logic          cfg_chg;
   logic          run_ok;
   logic          tick;
   logic          accept;
   logic          fwd_pulse;
   logic          load;
   logic [4:0]    win;
   logic [4:0]    ref_idx;

   // Window length of the currently shadowed mode; 8pt is held back for 16 refreshes.
   always_comb begin
      win = 5'd1;
      case (eng_mode)
         3'b000:  win = 5'd1;
         3'b001:  win = 5'd2;
         3'b010:  win = 5'd3;
         3'b011:  win = 5'd4;
         3'b100:  win = 5'd16;
         3'b101:  win = 5'd16;
         default: win = 5'd1;
      endcase
   end

   assign running    = state[1];
   assign eng_rst_n  = running;
   assign eng_enable = running;
   assign cfg_chg    = (cfg_mode != eng_mode) | (cfg_orm != eng_orm) | (cfg_period != period_sh);
   assign run_ok     = running & cfg_en & ~cfg_chg;
   assign tick       = (tick_cnt == period_sh);
   assign src_ready  = run_ok & tick;
   assign accept     = src_ready & src_valid;
   assign ref_idx    = ref_cnt + 5'd1;
   assign fwd_pulse  = eng_pulse & fwd_p & run_ok;
   assign load       = fwd_pulse & (~m_valid | m_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         eng_mode  <= 3'b000;
         eng_orm   <= 1'b0;
         period_sh <= '0;
         tick_cnt  <= '0;
         rst_cnt   <= 1'b0;
         ref_cnt   <= 5'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_en) begin
                  eng_mode  <= cfg_mode;
                  eng_orm   <= cfg_orm;
                  period_sh <= cfg_period;
                  rst_cnt   <= 1'b0;
                  state     <= S_ENG_RST;
               end
            end
            S_ENG_RST: begin
               if (!cfg_en) begin
                  state <= S_IDLE;
               end else if (rst_cnt) begin
                  tick_cnt <= '0;
                  ref_cnt  <= 5'd0;
                  state    <= S_WARMUP;
               end else begin
                  rst_cnt <= 1'b1;
               end
            end
            default: begin
               if (!cfg_en) begin
                  state <= S_IDLE;
               end else if (cfg_chg) begin
                  eng_mode  <= cfg_mode;
                  eng_orm   <= cfg_orm;
                  period_sh <= cfg_period;
                  rst_cnt   <= 1'b0;
                  state     <= S_ENG_RST;
               end else begin
                  tick_cnt <= tick ? '0 : tick_cnt + PW'(1);
                  if (state == S_WARMUP && accept) begin
                     ref_cnt <= ref_idx;
                     if (ref_idx == win)
                        state <= S_RUN;
                  end
               end
            end
         endcase
      end
   end

   // The forward flag travels with the refresh, then one more stage so it lines up with the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_data_refresh <= 1'b0;
         eng_din          <= '0;
         fwd_r            <= 1'b0;
         fwd_p            <= 1'b0;
      end else begin
         eng_data_refresh <= accept;
         if (accept)
            eng_din <= src_data;
         fwd_r <= accept & ((ref_idx >= win) | (state == S_RUN));
         fwd_p <= eng_data_refresh & fwd_r & run_ok;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_data  <= '0;
         m_valid <= 1'b0;
      end else if (load) begin
         m_data  <= eng_dout;
         m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underrun <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (run_ok && tick && !src_valid)
            underrun <= 1'b1;
         else if (clr_status)
            underrun <= 1'b0;
         if (fwd_pulse && m_valid && !m_ready)
            overrun <= 1'b1;
         else if (clr_status)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mavg_ctrl.sv
// Directed bench for mavg_ctrl with a simple echo model of the moving-average engine.
module tb_mavg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_en;
   logic [2:0]  cfg_mode;
   logic        cfg_orm;
   logic [15:0] cfg_period;
   logic        clr_status;
   logic [15:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic        eng_rst_n;
   logic        eng_enable;
   logic        eng_data_refresh;
   logic [15:0] eng_din;
   logic [2:0]  eng_mode;
   logic        eng_orm;
   logic [15:0] eng_dout;
   logic        eng_pulse;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        underrun;
   logic        overrun;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;
   int first;
   int nref;
   int ok;

   mavg_ctrl #(.DW(16), .PW(16)) dut (
      .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_orm(cfg_orm),
      .cfg_period(cfg_period), .clr_status(clr_status), .src_data(src_data),
      .src_valid(src_valid), .src_ready(src_ready), .eng_rst_n(eng_rst_n),
      .eng_enable(eng_enable), .eng_data_refresh(eng_data_refresh), .eng_din(eng_din),
      .eng_mode(eng_mode), .eng_orm(eng_orm), .eng_dout(eng_dout), .eng_pulse(eng_pulse),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .underrun(underrun),
      .overrun(overrun), .state(state)
   );

   always #5 clk = ~clk;

   // Engine stand-in: one-cycle result pulse after each refresh, echoing the sample.
   always @(posedge clk or posedge rst) begin
      if (rst || !eng_rst_n) begin
         eng_pulse <= 1'b0;
         eng_dout  <= 16'd0;
      end else begin
         eng_pulse <= eng_data_refresh;
         if (eng_data_refresh)
            eng_dout <= eng_din;
      end
   end

   task automatic applyStimulus(input logic en, input logic [2:0] mode, input logic orm,
                                input logic [15:0] period, input logic [15:0] data,
                                input logic valid, input logic ready);
      cfg_en     = en;
      cfg_mode   = mode;
      cfg_orm    = orm;
      cfg_period = period;
      src_data   = data;
      src_valid  = valid;
      m_ready    = ready;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst        = 1'b1;
      clr_status = 1'b0;
      applyStimulus(1'b0, 3'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("rst_state", state, 0);
      checkOutput("rst_eng_rst_n", eng_rst_n, 0);
      checkOutput("rst_eng_enable", eng_enable, 0);
      checkOutput("rst_refresh", eng_data_refresh, 0);
      checkOutput("rst_m_data", m_data, 0);
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_flags", {underrun, overrun}, 0);
      checkOutput("rst_src_ready", src_ready, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("idle_hold", state, 0);

      // Pass-through, one sample per cycle.
      applyStimulus(1'b1, 3'd0, 1'b1, 16'd0, 16'd1, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("pt_engrst_state", state, 1);
      checkOutput("pt_engrst_n", eng_rst_n, 0);
      repeat (2) @(negedge clk);
      checkOutput("pt_warmup_state", state, 2);
      for (int j = 1; j <= 10; j++) begin
         src_data = 16'(j);
         checkOutput("pt_ready", src_ready, 1);
         if (j >= 4) begin
            checkOutput("pt_data", m_data, 32'(j - 3));
            checkOutput("pt_valid", m_valid, 1);
         end
         @(negedge clk);
      end
      checkOutput("pt_overrun", overrun, 0);
      checkOutput("pt_run_state", state, 3);
      cfg_en = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("dis_state", state, 0);
      checkOutput("dis_m_valid", m_valid, 0);

      // 16-point warm-up at one sample every four cycles.
      applyStimulus(1'b1, 3'd5, 1'b1, 16'd3, 16'd100, 1'b1, 1'b1);
      first = 0;
      nref  = 0;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (m_valid) begin
            first = i;
            break;
         end
         if (eng_data_refresh) nref++;
      end
      checkOutput("w16_first_valid", first, 69);
      checkOutput("w16_refreshes", nref, 16);
      checkOutput("w16_data", m_data, 100);
      checkOutput("w16_state", state, 3);
      checkOutput("w16_mode", eng_mode, 5);
      checkOutput("w16_orm", eng_orm, 1);

      // Reconfigure to 2pt, period 0, and run until a result is buffered.
      applyStimulus(1'b1, 3'd1, 1'b1, 16'd0, 16'd7, 1'b1, 1'b1);
      ok = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (state == 2'd3 && m_valid) begin
            ok = 1;
            break;
         end
      end
      checkOutput("m2_reached", ok, 1);
      checkOutput("m2_data", m_data, 7);

      // 2pt -> 8pt while the old result is still unconsumed.
      applyStimulus(1'b1, 3'd4, 1'b1, 16'd0, 16'd8, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("rc_c1_state", state, 1);
      checkOutput("rc_c1_rst_n", eng_rst_n, 0);
      checkOutput("rc_keep_valid", m_valid, 1);
      checkOutput("rc_keep_data", m_data, 7);
      @(negedge clk);
      checkOutput("rc_c2_state", state, 1);
      checkOutput("rc_c2_rst_n", eng_rst_n, 0);
      @(negedge clk);
      checkOutput("rc_c3_state", state, 2);
      checkOutput("rc_c3_rst_n", eng_rst_n, 1);
      m_ready = 1'b1;
      first = 0;
      for (int i = 4; i <= 40; i++) begin
         @(negedge clk);
         if (m_valid) begin
            first = i;
            break;
         end
      end
      checkOutput("rc_first_valid", first, 21);
      checkOutput("rc_data", m_data, 8);
      checkOutput("rc_state", state, 3);

      // Underrun and status clear.
      checkOutput("ur_pre", underrun, 0);
      src_valid = 1'b0;
      @(negedge clk);
      checkOutput("ur_set", underrun, 1);
      checkOutput("ur_no_refresh", eng_data_refresh, 0);
      src_valid  = 1'b1;
      clr_status = 1'b1;
      @(negedge clk);
      checkOutput("ur_clr", underrun, 0);
      checkOutput("ur_overrun", overrun, 0);

      // Backpressure with pass-through: 5 is held, 9 is dropped.
      clr_status = 1'b0;
      applyStimulus(1'b1, 3'd0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      checkOutput("bp_warmup", state, 2);
      checkOutput("bp_empty", m_valid, 0);
      src_valid = 1'b1;
      src_data  = 16'd5;
      m_ready   = 1'b0;
      @(negedge clk);
      src_data = 16'd9;
      @(negedge clk);
      src_valid = 1'b0;
      @(negedge clk);
      checkOutput("bp_valid", m_valid, 1);
      checkOutput("bp_data", m_data, 5);
      checkOutput("bp_no_overrun_yet", overrun, 0);
      @(negedge clk);
      checkOutput("bp_hold_data", m_data, 5);
      checkOutput("bp_hold_valid", m_valid, 1);
      checkOutput("bp_overrun", overrun, 1);
      m_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_drained", m_valid, 0);
      checkOutput("bp_data_kept", m_data, 5);

      // Asynchronous reset away from any clock edge.
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_state", state, 0);
      checkOutput("arst_rst_n", eng_rst_n, 0);
      checkOutput("arst_m_data", m_data, 0);
      checkOutput("arst_din", eng_din, 0);
      checkOutput("arst_flags", {underrun, overrun, m_valid}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mavg_ctrl.md
# mavg_ctrl

Sequencing controller for one moving-average engine. It paces input samples at a programmable period, drives the engine's `data_refresh`/`din`/`mode` pins, and re-initialises the engine through its active-low reset on every configuration change. It suppresses engine results until the selected window has filled, then buffers each valid result into a single-entry valid/ready output stage. It sits between the sample source and the downstream consumer and wraps the engine instance.

## Interface
- `DW`, 16: sample/result width (signed).
- `PW`, 16: sample-period counter width.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `cfg_en`  in  1  run enable (level).
- `cfg_mode`  in  3  averaging mode, engine encoding (000 none, 001 2pt, 010 3pt, 011 4pt, 100 8pt, 101 16pt).
- `cfg_orm`  in  1  engine output-refresh mode.
- `cfg_period`  in  PW  sample interval minus one, in clk cycles.
- `clr_status`  in  1  clears the sticky flags.
- `src_data`  in  DW  input sample.
- `src_valid`  in  1  source has a sample.
- `src_ready`  out  1  sample accepted this cycle (combinational).
- `eng_rst_n`  out  1  engine reset, active-low.
- `eng_enable`  out  1  engine enable.
- `eng_data_refresh`  out  1  engine refresh pulse (registered).
- `eng_din`  out  DW  engine input (registered).
- `eng_mode`  out  3  shadowed mode.
- `eng_orm`  out  1  shadowed output-refresh mode.
- `eng_dout`  in  DW  engine result.
- `eng_pulse`  in  1  engine result-valid pulse.
- `m_data`  out  DW  buffered result.
- `m_valid`  out  1  buffer full.
- `m_ready`  in  1  consumer accepts.
- `underrun`  out  1  sticky: a tick occurred with no sample available.
- `overrun`  out  1  sticky: a result was dropped because the buffer was full.
- `state`  out  2  FSM state.

## Operation
- FSM states: IDLE=00, ENG_RST=01, WARMUP=10, RUN=11. Reset state is IDLE.
- Transition priority, highest first:
  1. `cfg_en`=0 sends every state to IDLE.
  2. A config change in WARMUP or RUN sends the FSM to ENG_RST. A config change means any of `cfg_mode`, `cfg_orm` or `cfg_period` differs from its shadow.
  3. Normal progress.
- IDLE: `eng_rst_n`=0, `eng_enable`=0. When `cfg_en`=1, latch the shadows, go to ENG_RST and clear `rst_cnt`.
- ENG_RST: `eng_rst_n`=0 for exactly 2 cycles, then go to WARMUP. On WARMUP entry: tick counter=0, refresh count=0.
- WARMUP and RUN: `eng_rst_n`=1, `eng_enable`=1.
  - The tick counter counts 0..period and asserts tick when it equals period, then wraps to 0.
  - `src_ready` = tick & `cfg_en` & no config change & (WARMUP|RUN).
  - On accept, the next cycle has `eng_data_refresh`=1 and `eng_din`=accepted `src_data`; otherwise `eng_data_refresh`=0 and `eng_din` holds its value.
  - A tick with `src_valid`=0 sets `underrun`, issues no refresh, and the counter continues.
- Window size W: 000→1, 001→2, 010→3, 011→4, 100→16, 101→16, others→1.
- WARMUP counts issued refreshes. After the W-th refresh the FSM moves to RUN.
- `fwd_ok` is registered alongside each refresh and is 1 when the refresh index ≥ W, or when in RUN.
- `eng_pulse` with `fwd_ok` set loads the buffer; a pulse with `fwd_ok`=0 is discarded.
- Buffer load occurs when a forwarded pulse arrives and (`m_valid`=0 or `m_ready`=1). In that case `m_data`←`eng_dout`, `m_valid`=1.
  - If a forwarded pulse arrives while `m_valid`=1 and `m_ready`=0: set `overrun`, keep the old data, drop the new result.
  - `m_valid`=1 with `m_ready`=1 and no load clears `m_valid`.
- The buffer keeps its contents across IDLE/ENG_RST. A refresh or pulse in flight at the time of a config change or disable is dropped.
- `clr_status` clears both flags. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values: all outputs 0 (including `eng_rst_n`=0, `m_data`=0, `state`=00).
- Accept at edge T → `eng_data_refresh` high in cycle T+1 → `eng_pulse` in T+2 → `m_valid` from T+3. Sample-to-result latency is 3 cycles.
- `cfg_period`=0 gives 1 sample/cycle. With `m_ready` held at 1, sustained throughput is 1 result/cycle with no overrun.
- Config change detected at cycle C: `state`=01 at C+1. `eng_rst_n` is low for C+1 and C+2. WARMUP begins at C+3, and the first tick is at C+3+period.
- Asserting `rst` mid-operation returns all outputs to reset values immediately (asynchronously).

## Test plan
- Reset: `rst`=1 for 3 cycles → all outputs 0 and `state`=00. After release with `cfg_en`=0, `state` stays 00.
- Pass-through: mode 000, `cfg_orm`=1, `cfg_period`=0, ramp 1,2,3…, `m_ready`=1 → `m_data` = 1,2,3… each 3 cycles after accept, with no drops.
- 16pt warm-up: mode 101, `cfg_orm`=1, `cfg_period`=3, constant 100 → refreshes every 4 cycles, first 15 pulses discarded, first `m_valid` after the 16th refresh with `m_data`=100, then `state`=11.
- Reconfig: in RUN, `cfg_mode` 001→100 → `state` goes 01 then 10, `eng_rst_n` is low exactly 2 cycles, the next `m_valid` occurs only after 16 new refreshes, and the old buffered data remains until consumed.
- Underrun: `src_valid`=0 at a tick → `underrun`=1, no `eng_data_refresh`. Then `clr_status`=1 → `underrun`=0.
- Backpressure: `m_ready`=0, mode 000, samples 5 then 9 → `m_data`=5 holds and `overrun`=1. Then `m_ready`=1 → 5 is consumed and `m_valid`=0.
